// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the memory-stage responder.
package mips_mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int DEF_DEPTH   = 1024;
    localparam int DEF_LATENCY = 2;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/mem_array.sv
// Single-port 16-bit word store: synchronous write, combinational read.
module mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);
    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the pipeline memory stage.
// Optional fault checking (misaligned / out of range) enabled by MEM_RESP_ERR_EN.
module mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);
    localparam int AW = idx_w(DEPTH);

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;

    logic        in_idle;
    logic        commit;
    logic        commit_wr;
    logic [31:0] commit_addr;
    logic [15:0] commit_data;
    logic        we;
    logic [15:0] arr_rdata;

    function automatic logic addr_fault(input logic [31:0] a);
`ifdef MEM_RESP_ERR_EN
        return a[0] || (a >= 32'(2 * DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    assign in_idle = (state == IDLE);

    // With zero latency the write lands on the accepting edge, so it comes straight from the inputs.
    assign commit      = (in_idle && req && (LATENCY == 0)) || (state == WAIT && cnt == 4'd1);
    assign commit_wr   = in_idle ? wr    : wr_q;
    assign commit_addr = in_idle ? addr  : addr_q;
    assign commit_data = in_idle ? wdata : wdata_q;
    assign we          = !rst && commit && commit_wr && !addr_fault(commit_addr);

    mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .we    (we),
        .addr  (commit_addr[AW:1]),
        .wdata (commit_data),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        wr_q    <= wr;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ack   = (state == RESP);
    assign err   = ack && addr_fault(addr_q);
    assign rdata = (ack && !wr_q && !addr_fault(addr_q)) ? arr_rdata : 16'h0000;
    assign busy  = (in_idle && req) || (state == WAIT);

    logic unused_bits;
    assign unused_bits = ^{addr_q[31:AW+1], addr_q[0], addr[31:AW+1], addr[0]};
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_mem_responder;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic        req_a, wr_a, ack_a, busy_a, err_a;
    logic [31:0] addr_a;
    logic [15:0] wdata_a, rdata_a;
    logic        req_b, wr_b, ack_b, busy_b, err_b;
    logic [31:0] addr_b;
    logic [15:0] wdata_b, rdata_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(1024), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .wr(wr_a), .addr(addr_a), .wdata(wdata_a),
        .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .err(err_a)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .wr(wr_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .err(err_b)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w, input logic [31:0] a,
                         input logic [15:0] d);
        if (sel == 0) begin
            req_a = r; wr_a = w; addr_a = a; wdata_a = d;
        end else begin
            req_b = r; wr_b = w; addr_b = a; wdata_b = d;
        end
    endtask

    // Called at a falling edge; completes one request and returns at the falling edge after ack.
    task automatic xact(input int sel, input logic w, input logic [31:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input logic exp_err);
        int  lat;
        int  nb;
        bit  got;
        logic a_ack, a_busy, a_err;
        logic [15:0] a_rd;
        lat = (sel == 0) ? 2 : 0;
        nb  = 0;
        got = 1'b0;
        drive(sel, 1'b1, w, a, d);
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            a_ack  = (sel == 0) ? ack_a  : ack_b;
            a_busy = (sel == 0) ? busy_a : busy_b;
            a_err  = (sel == 0) ? err_a  : err_b;
            a_rd   = (sel == 0) ? rdata_a : rdata_b;
            if (a_ack) begin
                got = 1'b1;
                chk("ack_cycle", c, lat + 1);
                chk("busy_cycles", nb, lat + 1);
                chk("busy_in_ack", a_busy, 1'b0);
                chk("rdata", a_rd, exp_rd);
                chk("err", a_err, exp_err);
                drive(sel, 1'b0, 1'b0, 32'h0, 16'h0);
            end else if (a_busy) begin
                nb++;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk("ack_timeout", 0, 1);
            drive(sel, 1'b0, 1'b0, 32'h0, 16'h0);
        end
        #1;
        chk("ack_one_cycle", (sel == 0) ? ack_a : ack_b, 1'b0);
    endtask

    initial begin
        int acks;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 16'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ack_a", ack_a, 1'b0);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_err_a", err_a, 1'b0);
        chk("rst_rdata_a", rdata_a, 16'h0000);
        chk("rst_ack_b", ack_b, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        tbl.push_back('{1'b1, 32'h10,  16'hBEEF, 16'h0000, 1'b0});
        tbl.push_back('{1'b0, 32'h10,  16'h0000, 16'hBEEF, 1'b0});
`ifdef MEM_RESP_ERR_EN
        tbl.push_back('{1'b1, 32'h11,  16'h5555, 16'h0000, 1'b1});
        tbl.push_back('{1'b1, 32'h800, 16'h6666, 16'h0000, 1'b1});
        tbl.push_back('{1'b0, 32'h10,  16'h0000, 16'hBEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h11,  16'h0000, 16'h0000, 1'b1});
`else
        tbl.push_back('{1'b1, 32'h802, 16'h1234, 16'h0000, 1'b0});
        tbl.push_back('{1'b0, 32'h2,   16'h0000, 16'h1234, 1'b0});
`endif
        tbl.push_back('{1'b1, 32'h7FE, 16'hA1A1, 16'h0000, 1'b0});
        tbl.push_back('{1'b1, 32'h7FC, 16'hB2B2, 16'h0000, 1'b0});
        tbl.push_back('{1'b0, 32'h7FC, 16'h0000, 16'hB2B2, 1'b0});
        tbl.push_back('{1'b0, 32'h7FE, 16'h0000, 16'hA1A1, 1'b0});
        tbl.push_back('{1'b1, 32'hA,   16'h0505, 16'h0000, 1'b0});

        foreach (tbl[i]) begin
            xact(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);
        end

        // Reset during WAIT of a write must drop it without committing.
        drive(0, 1'b1, 1'b1, 32'hA, 16'hAAAA);
        @(negedge clk);
        #1;
        chk("abort_busy_wait", busy_a, 1'b1);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 16'h0);
        @(negedge clk);
        #1;
        chk("abort_state", dut_a.state, IDLE);
        chk("abort_ack", ack_a, 1'b0);
        chk("abort_busy", busy_a, 1'b0);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (ack_a) acks++;
        end
        chk("abort_no_ack", acks, 0);
        @(negedge clk);
        xact(0, 1'b0, 32'hA, 16'h0000, 16'h0505, 1'b0);

        // Zero latency: one write, then reads with req held high.
        xact(1, 1'b1, 32'h10, 16'h7777, 16'h0000, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h10, 16'h0);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("b2b_ack_pattern", ack_b, (i % 2) == 1);
            chk("b2b_busy_vs_ack", busy_b, !ack_b);
            if (ack_b) begin
                acks++;
                chk("b2b_rdata", rdata_b, 16'h7777);
            end
            if (i == 9) drive(1, 1'b0, 1'b0, 32'h0, 16'h0);
            @(negedge clk);
        end
        chk("b2b_ack_count", acks, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
